mult_nxn: RTL

MULT_NXN -- requirements
Module: mult_nxn

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_pp.sv | 12 +
 rtl/mult_nxn.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the chunked multiplier.
// The FIX state only exists when MULT_SIGNED_EN is defined.
package mult_pkg;

`ifdef MULT_SIGNED_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;
`endif

  // Number of CHUNKxCHUNK partial products per full multiplication.
  function automatic int num_pp(input int width, input int chunk);
    return (width / chunk) * (width / chunk);
  endfunction

endpackage

// File: rtl/mult_pp.sv
// Combinational CHUNKxCHUNK unsigned multiplier used once per cycle by mult_nxn.
module mult_pp #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0]   x,
  input  logic [CHUNK-1:0]   y,
  output logic [2*CHUNK-1:0] p
);

  assign p = {{CHUNK{1'b0}}, x} * {{CHUNK{1'b0}}, y};

endmodule

// File: rtl/mult_nxn.sv
// Sequential WIDTHxWIDTH multiplier: one CHUNK-wide partial product per cycle.
// Define MULT_SIGNED_EN to add the is_signed port and the sign-fix state.
module mult_nxn
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int D   = WIDTH / CHUNK;
  localparam int N   = num_pp(WIDTH, CHUNK);
  localparam int IW  = (D > 1) ? $clog2(D) : 1;
  localparam int CW  = $clog2(N + 1) + 1;
  localparam int SW  = $clog2(2 * D);
  localparam int SHW = $clog2(2 * WIDTH);

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_param
    $error("mult_nxn: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t               state_reg;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        cnt_reg;
  logic [IW-1:0]        i_reg, j_reg;
  logic [2*CHUNK-1:0]   pp_reg;
  logic [SW-1:0]        sh_reg;
  logic [2*WIDTH-1:0]   product_reg;
  logic                 done_reg;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [CHUNK-1:0]     a_digs [D];
  logic [CHUNK-1:0]     b_digs [D];
  logic [2*CHUNK-1:0]   pp_next;
  logic [SHW-1:0]       shift_amt;
  logic [2*WIDTH-1:0]   acc_sum;

`ifdef MULT_SIGNED_EN
  logic                 neg_reg;
  logic                 neg_in;

  always_comb begin
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
    neg_in = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  always_comb begin
    a_mag = a;
    b_mag = b;
  end
`endif

  genvar gi;
  for (gi = 0; gi < D; gi++) begin : g_dig
    assign a_digs[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_digs[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  mult_pp #(.CHUNK(CHUNK)) u_pp (
    .x (a_digs[i_reg]),
    .y (b_digs[j_reg]),
    .p (pp_next)
  );

  // The partial product is registered first, so the accumulator trails the
  // digit walk by one cycle and RUN drains for one extra cycle at the end.
  always_comb begin
    shift_amt = SHW'(sh_reg) * SHW'(CHUNK);
    acc_sum   = acc_reg + ((2*WIDTH)'(pp_reg) << shift_amt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      i_reg       <= '0;
      j_reg       <= '0;
      pp_reg      <= '0;
      sh_reg      <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a_mag;
            b_reg     <= b_mag;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            state_reg <= RUN;
`ifdef MULT_SIGNED_EN
            neg_reg   <= neg_in;
`endif
          end
        end
        RUN: begin
          pp_reg  <= pp_next;
          sh_reg  <= SW'(i_reg) + SW'(j_reg);
          cnt_reg <= cnt_reg + 1'b1;
          if (j_reg == IW'(D - 1)) begin
            j_reg <= '0;
            i_reg <= i_reg + 1'b1;
          end else begin
            j_reg <= j_reg + 1'b1;
          end
          if (cnt_reg != '0) begin
            acc_reg <= acc_sum;
          end
          if (cnt_reg == CW'(N)) begin
`ifdef MULT_SIGNED_EN
            state_reg   <= FIX;
`else
            state_reg   <= IDLE;
            product_reg <= acc_sum;
            done_reg    <= 1'b1;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        FIX: begin
          acc_reg     <= neg_reg ? -acc_reg : acc_reg;
          product_reg <= neg_reg ? -acc_reg : acc_reg;
          done_reg    <= 1'b1;
          state_reg   <= IDLE;
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign product = product_reg;

endmodule
